// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state type and its encoding.
package serial_sub_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit step borrows.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign d     = w_axb ^ bin;
   assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first, one bit per clock through one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic [1:0]       o_dbg_state
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   sub_state_t       r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_res_sr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_borrow;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_ovf;
`endif

   logic             w_d;
   logic             w_bnext;
   logic [WIDTH-1:0] w_res_next;
   logic             w_last;

   full_subtractor u_fs (
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bnext)
   );

   // Shift form keeps WIDTH=1 legal (no zero-width slice).
   assign w_res_next = (r_res_sr >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_res_sr <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_ovf    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a_sr   <= a;
                  r_b_sr   <= b;
                  r_borrow <= bin;
                  r_cnt    <= '0;
                  r_res_sr <= '0;
`ifdef SERIAL_SUB_OVF_EN
                  r_a_msb  <= a[WIDTH-1];
                  r_b_msb  <= b[WIDTH-1];
`endif
                  r_busy   <= 1'b1;
                  r_state  <= SHIFT;
               end else begin
                  r_state  <= IDLE;
               end
            end
            SHIFT: begin
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               r_res_sr <= w_res_next;
               r_borrow <= w_bnext;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_diff  <= w_res_next;
                  r_bout  <= w_bnext;
`ifdef SERIAL_SUB_OVF_EN
                  r_ovf   <= (r_a_msb != r_b_msb) & (w_res_next[WIDTH-1] != r_a_msb);
`endif
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign diff        = r_diff;
   assign bout        = r_bout;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf         = r_ovf;
`endif
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
// Define SERIAL_SUB_OVF_EN to also exercise the ovf output.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif
   logic [1:0]   dbg_state;

   int           n_checks = 0;
   int           n_pass   = 0;
   logic [9:0]   exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .bin         (bin),
      .busy        (busy),
      .done        (done),
      .diff        (diff),
      .bout        (bout),
`ifdef SERIAL_SUB_OVF_EN
      .ovf         (ovf),
`endif
      .o_dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: plain integer arithmetic, returns {ovf, bout, diff}.
   function automatic logic [9:0] ref_model(input logic [7:0] ai, input logic [7:0] bi, input logic ci);
      int r;
      int sr;
      logic [7:0] d;
      r  = int'(ai) - int'(bi) - int'(ci);
      sr = int'($signed(ai)) - int'($signed(bi)) - int'(ci);
      d  = r[7:0];
      return {(sr > 127 || sr < -128), (r < 0), d};
   endfunction

   // scoreboard: every done pulse is compared against the oldest expectation
   always @(negedge clk) begin
      logic [9:0] e;
      if (done) begin
         check("busy_with_done", busy, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("sb_diff", diff, e[7:0]);
            check("sb_bout", bout, e[8]);
`ifdef SERIAL_SUB_OVF_EN
            check("sb_ovf", ovf, e[9]);
`endif
         end
      end
   end

   // drivers
   task automatic apply(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input bit push);
      @(negedge clk);
      start = 1'b1;
      a     = ai;
      b     = bi;
      bin   = ci;
      if (push) exp_q.push_back(ref_model(ai, bi, ci));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called one cycle after the accepting edge; lat counts cycles since that edge.
   task automatic wait_done(output int lat, output int nbusy);
      lat   = 1;
      nbusy = 0;
      while (!done && lat < 40) begin
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   initial begin
      int lat;
      int nb;
      int ndone;
      bit got_done;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_bout", bout, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;

      apply(8'h5A, 8'h23, 1'b0, 1'b1);
      wait_done(lat, nb);
      check("t1_latency", lat, 9);
      check("t1_busy_cycles", nb, 8);
      check("t1_diff", diff, 8'h37);
      check("t1_bout", bout, 0);

      apply(8'h10, 8'h20, 1'b0, 1'b1);
      wait_done(lat, nb);
      check("t2_diff", diff, 8'hF0);
      check("t2_bout", bout, 1);
      apply(8'h00, 8'h00, 1'b1, 1'b1);
      wait_done(lat, nb);
      check("t2b_diff", diff, 8'hFF);
      check("t2b_bout", bout, 1);
      repeat (3) @(negedge clk);
      check("hold_diff", diff, 8'hFF);

      // reset four cycles into SHIFT discards the operation
      apply(8'hAA, 8'h55, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("mid_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      check("mrst_diff", diff, 0);
      check("mrst_bout", bout, 0);
      check("mrst_state", dbg_state, 0);
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("mrst_no_done", ndone, 0);

      // start held during busy is ignored; start in DONE chains back-to-back
      @(negedge clk);
      start = 1'b1;
      a     = 8'h9C;
      b     = 8'h47;
      bin   = 1'b1;
      exp_q.push_back(ref_model(8'h9C, 8'h47, 1'b1));
      got_done = 1'b0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
            a   = 8'h01;
            b   = 8'h01;
            bin = 1'b0;
            exp_q.push_back(ref_model(8'h01, 8'h01, 1'b0));
         end else begin
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
         end
      end
      if (!got_done) check("held_timeout", 0, 1);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy_now", busy, 1);
      wait_done(lat, nb);
      check("b2b_latency", lat, 9);
      check("b2b_diff", diff, 8'h00);
      check("b2b_bout", bout, 0);

`ifdef SERIAL_SUB_OVF_EN
      apply(8'h80, 8'h01, 1'b0, 1'b1);
      wait_done(lat, nb);
      check("ovf1_diff", diff, 8'h7F);
      check("ovf1_ovf", ovf, 1);
      apply(8'h7F, 8'hFF, 1'b0, 1'b1);
      wait_done(lat, nb);
      check("ovf2_diff", diff, 8'h80);
      check("ovf2_ovf", ovf, 1);
      apply(8'h05, 8'h03, 1'b0, 1'b1);
      wait_done(lat, nb);
      check("ovf3_ovf", ovf, 0);
`endif

      // random operands, scoreboard checks each result
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         apply(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
         wait_done(lat, nb);
      end

      @(negedge clk);
      check("exp_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
